// File: rtl/alu_issue.sv
// Single-issue RV32 OP instruction sequencer in front of a one-cycle registered ALU.
// Optional OP-IMM support is compiled in when ALU_ISSUE_OPIMM_EN is defined.
module alu_issue #(
  parameter bit WRITE_X0 = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [31:0] ALUin1,
  output logic [31:0] ALUin2,
  input  logic [31:0] ALUout,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        illegal,
  output logic        busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_ADD    = 3'b000;
`ifdef ALU_ISSUE_OPIMM_EN
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
`endif

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q;
  logic        accept;
  logic        dec_legal;
  logic [6:0]  dec_f7;
  logic [31:0] dec_in2;

  wire [6:0] opcode = instr[6:0];
  wire [2:0] f3     = instr[14:12];
  wire [6:0] f7     = instr[31:25];

  assign rf_raddr1 = instr[19:15];
  assign rf_raddr2 = instr[24:20];
  assign accept    = instr_valid && instr_ready;

  // Decode: legality plus the func7 / operand-2 shaping the ALU expects.
  // The ALU's right-shift encoding is inverted relative to RISC-V, hence the swap.
  always_comb begin
    dec_legal = 1'b0;
    dec_f7    = F7_ZERO;
    dec_in2   = rf_rdata2;
    case (opcode)
      OPC_OP: begin
        dec_legal = (f7 == F7_ZERO) ||
                    ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        dec_f7    = f7;
        if (f3 == F3_SR)
          dec_f7 = (f7 == F7_ZERO) ? F7_ALT : F7_ZERO;
        if ((f3 == F3_SLL) || (f3 == F3_SR))
          dec_in2 = {(XLEN-SHW)'(0), rf_rdata2[SHW-1:0]};
      end
`ifdef ALU_ISSUE_OPIMM_EN
      OPC_OPIMM: begin
        dec_legal = 1'b1;
        dec_in2   = {{(XLEN-12){instr[31]}}, instr[31:20]};
        if (f3 == F3_SLL) begin
          dec_legal = (f7 == F7_ZERO);
          dec_in2   = {(XLEN-SHW)'(0), instr[24:20]};
        end else if (f3 == F3_SR) begin
          dec_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
          dec_f7    = (f7 == F7_ZERO) ? F7_ALT : F7_ZERO;
          dec_in2   = {(XLEN-SHW)'(0), instr[24:20]};
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && dec_legal) state_d = DRIVE;
      DRIVE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    instr_ready = (state_q == IDLE) && rst_n;
    busy        = (state_q != IDLE);
    if (state_q == WRITE) begin
      rf_we    = WRITE_X0 || (rd_q != 5'd0);
      rf_waddr = rd_q;
      if (rf_we) rf_wdata = ALUout;
    end
  end

  // Operand registers only load on a legal handshake so the ALU never sees bad encodings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func3   <= 3'd0;
      func7   <= 7'd0;
      ALUin1  <= 32'd0;
      ALUin2  <= 32'd0;
      rd_q    <= 5'd0;
      illegal <= 1'b0;
    end else begin
      illegal <= accept && !dec_legal;
      if (accept && dec_legal) begin
        func3  <= f3;
        func7  <= dec_f7;
        ALUin1 <= rf_rdata1;
        ALUin2 <= dec_in2;
        rd_q   <= instr[11:7];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: RISC-V-level reference model plus directed vectors.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] ALUin1, ALUin2;
  logic [31:0] ALUout;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        illegal;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] regs [32];

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .func3(func3), .func7(func7),
    .ALUin1(ALUin1), .ALUin2(ALUin2), .ALUout(ALUout), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : regs[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : regs[rf_raddr2];

  // External ALU: registered, with its own (non-RISC-V) right-shift encoding.
  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return (f7 == 7'h20) ? a - b : a + b;
      3'd1: return a << b;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (f7 == 7'h00) ? 32'($signed(a) >>> b) : a >> b;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(posedge clk) ALUout <= alu_fn(func3, func7, ALUin1, ALUin2);

  // RISC-V architectural result: {legal, value}.
  function automatic logic [32:0] rv_exec(input logic [31:0] w, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic        ok;
    logic [31:0] r;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    ok  = 1'b0;
    r   = 32'd0;
    if (opc == 7'b0110011) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      sh = b[4:0];
      case (f3)
        3'd0: r = f7[5] ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
`ifdef ALU_ISSUE_OPIMM_EN
    else if (opc == 7'b0010011) begin
      imm = {{20{w[31]}}, w[31:20]};
      sh  = w[24:20];
      ok  = 1'b1;
      case (f3)
        3'd0: r = a + imm;
        3'd1: begin ok = (f7 == 7'h00); r = a << sh; end
        3'd2: r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: r = (a < imm) ? 32'd1 : 32'd0;
        3'd4: r = a ^ imm;
        3'd5: begin
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          r  = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
        end
        3'd6: r = a | imm;
        default: r = a & imm;
      endcase
    end
`endif
    return {ok, r};
  endfunction

  // Reference model: cycles remaining in the current instruction and pending result.
  int          mcnt  = 0;
  bit          m_acc = 1'b0;
  bit          m_ill = 1'b0;
  logic [4:0]  m_rd  = 5'd0;
  logic [31:0] m_res = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    logic [32:0] ex;
    if (!rst_n) begin
      mcnt = 0; m_acc = 1'b0; m_ill = 1'b0;
    end else begin
      m_acc = 1'b0;
      m_ill = 1'b0;
      if (mcnt != 0) mcnt = mcnt - 1;
      else if (instr_valid) begin
        m_acc = 1'b1;
        ex = rv_exec(instr, (instr[19:15] == 0) ? 32'd0 : regs[instr[19:15]],
                            (instr[24:20] == 0) ? 32'd0 : regs[instr[24:20]]);
        if (ex[32]) begin
          mcnt  = 2;
          m_rd  = instr[11:7];
          m_res = ex[31:0];
        end else m_ill = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic e_we;
    if (chk_en) begin
      e_we = (mcnt == 1) && (m_rd != 5'd0);
      chk("instr_ready", 32'(instr_ready), 32'(rst_n && mcnt == 0));
      chk("busy",        32'(busy),        32'(mcnt != 0));
      chk("illegal",     32'(illegal),     32'(m_ill));
      chk("rf_we",       32'(rf_we),       32'(e_we));
      chk("rf_waddr",    32'(rf_waddr),    (mcnt == 1) ? 32'(m_rd) : 32'd0);
      chk("rf_wdata",    rf_wdata,         e_we ? m_res : 32'd0);
      if (!rst_n) begin
        chk("rst_func3",  32'(func3), 32'd0);
        chk("rst_func7",  32'(func7), 32'd0);
        chk("rst_ALUin1", ALUin1,     32'd0);
        chk("rst_ALUin2", ALUin2,     32'd0);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Offer a word until the model takes it; returns at the start of cycle N+1.
  task automatic issue(input logic [31:0] w, input bit hold);
    instr       = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_acc) break;
    end
    if (!m_acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got 0 expected 1");
    end
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [31:0] burst [16];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // add x3,x1,x2
    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(32'h002081B3, 1'b0);
    @(negedge clk);
    chk("add_func3", 32'(func3), 32'd0);
    chk("add_func7", 32'(func7), 32'd0);
    chk("add_in1", ALUin1, 32'd5);
    chk("add_in2", ALUin2, 32'd7);
    @(negedge clk);
    chk("add_we", 32'(rf_we), 32'd1);
    chk("add_waddr", 32'(rf_waddr), 32'd3);
    chk("add_wdata", rf_wdata, 32'd12);
    drain();

    // sra x5,x1,x2
    regs[1] = 32'h80000000; regs[2] = 32'd4;
    issue(32'h4020D2B3, 1'b0);
    @(negedge clk);
    chk("sra_func7", 32'(func7), 32'd0);
    @(negedge clk);
    chk("sra_wdata", rf_wdata, 32'hF8000000);
    drain();

    // sll x6,x1,x2 with shift operand 35
    regs[1] = 32'd1; regs[2] = 32'd35;
    issue(32'h00209333, 1'b0);
    @(negedge clk);
    chk("sll_in2", ALUin2, 32'd3);
    @(negedge clk);
    chk("sll_wdata", rf_wdata, 32'd8);
    drain();

    // addi x4,x0,-1
    issue(32'hFFF00213, 1'b0);
    @(negedge clk);
`ifdef ALU_ISSUE_OPIMM_EN
    chk("addi_in2", ALUin2, 32'hFFFFFFFF);
    chk("addi_func7", 32'(func7), 32'd0);
    @(negedge clk);
    chk("addi_wdata", rf_wdata, 32'hFFFFFFFF);
`else
    chk("addi_illegal", 32'(illegal), 32'd1);
    @(negedge clk);
    chk("addi_illegal_off", 32'(illegal), 32'd0);
`endif
    drain();

    // load: rejected, ready stays high
    issue(32'h00000003, 1'b0);
    @(negedge clk);
    chk("load_illegal", 32'(illegal), 32'd1);
    chk("load_ready", 32'(instr_ready), 32'd1);
    chk("load_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    chk("load_illegal_off", 32'(illegal), 32'd0);
    drain();

    // reset during DRIVE, then normal execution
    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(32'h002081B3, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in1", ALUin1, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_we", 32'(rf_we), 32'd0);
    end
    issue(32'h002081B3, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("post_rst_wdata", rf_wdata, 32'd12);
    drain();

    // Back-to-back burst, instr_valid held high across busy cycles
    regs[8] = 32'hF0F01234; regs[9] = 32'h00000024; regs[10] = 32'hFFFFFFFE;
    burst[0]  = rtype(7'h00, 5'd9,  5'd8,  3'd5, 5'd7);
    burst[1]  = rtype(7'h20, 5'd9,  5'd8,  3'd5, 5'd11);
    burst[2]  = rtype(7'h20, 5'd10, 5'd8,  3'd0, 5'd12);
    burst[3]  = rtype(7'h00, 5'd10, 5'd8,  3'd4, 5'd13);
    burst[4]  = rtype(7'h00, 5'd10, 5'd8,  3'd6, 5'd14);
    burst[5]  = rtype(7'h00, 5'd10, 5'd8,  3'd7, 5'd15);
    burst[6]  = rtype(7'h00, 5'd8,  5'd10, 3'd2, 5'd16);
    burst[7]  = rtype(7'h00, 5'd8,  5'd10, 3'd3, 5'd17);
    burst[8]  = rtype(7'h01, 5'd9,  5'd8,  3'd0, 5'd18);
    burst[9]  = rtype(7'h20, 5'd9,  5'd8,  3'd1, 5'd19);
    burst[10] = rtype(7'h20, 5'd9,  5'd8,  3'd4, 5'd20);
    burst[11] = rtype(7'h00, 5'd9,  5'd8,  3'd0, 5'd0);
    burst[12] = rtype(7'h00, 5'd9,  5'd8,  3'd1, 5'd21);
    burst[13] = {12'h400, 5'd8, 3'd0, 5'd22, 7'b0010011};
    burst[14] = {7'h20, 5'd4, 5'd8, 3'd5, 5'd23, 7'b0010011};
    burst[15] = {7'h20, 5'd4, 5'd8, 3'd1, 5'd24, 7'b0010011};
    for (int i = 0; i < 16; i++) issue(burst[i], i < 15);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
